// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: sequences data-memory accesses for loads, stores,
// indirect loads/stores and TRAP vector fetches, stalling until done.
module mem_access_stage #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mem_op,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] sr2_in,
  input  logic [DATA_W-1:0] trapvect8_in,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [DATA_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [BE_W-1:0]   dmem_byte_en,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_stall
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_STR  = 3'd2;
  localparam logic [2:0] OP_LDB  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_TRAP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ptr_reg;

  logic indirect;
  logic final_resp;
  logic byte_op;

  assign indirect   = (mem_op == OP_LDI) || (mem_op == OP_STI);
  assign byte_op    = (mem_op == OP_LDB) || (mem_op == OP_STB);
  assign final_resp = dmem_resp &&
                      (((state == ACC1) && !indirect) ||
                       (state == ACC2));
  assign mem_stall  = ((state != IDLE) || (mem_op != OP_NONE)) &&
                      !final_resp;

  // Access sequencer; indirect ops latch the pointer on the first response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op != OP_NONE) state <= ACC1;
        end
        ACC1: begin
          if (dmem_resp) begin
            if (indirect) begin
              ptr_reg <= dmem_rdata;
              state   <= ACC2;
            end else begin
              state <= IDLE;
            end
          end
        end
        ACC2: begin
          if (dmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request decode: address and read/write level from state and op.
  always_comb begin
    dmem_address = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    if (state == ACC1) begin
      if (mem_op == OP_TRAP)
        dmem_address = {trapvect8_in[DATA_W-2:0], 1'b0};
      else if (byte_op)
        dmem_address = addr_in;
      else
        dmem_address = {addr_in[DATA_W-1:1], 1'b0};
      dmem_write = (mem_op == OP_STR) || (mem_op == OP_STB);
      dmem_read  = (mem_op != OP_NONE) && !dmem_write;
    end else if (state == ACC2) begin
      dmem_address = {ptr_reg[DATA_W-1:1], 1'b0};
      dmem_read    = (mem_op == OP_LDI);
      dmem_write   = (mem_op == OP_STI);
    end
  end

  // Write lanes; quiet whenever no write is requested.
  always_comb begin
    dmem_byte_en = '0;
    dmem_wdata   = '0;
    if (dmem_write) begin
      if (mem_op == OP_STB) begin
        dmem_byte_en = addr_in[0] ? 2'b10 : 2'b01;
        dmem_wdata   = {sr2_in[7:0], sr2_in[7:0]};
      end else begin
        dmem_byte_en = 2'b11;
        dmem_wdata   = sr2_in;
      end
    end
  end

  // Load result, only meaningful in the final-response cycle.
  always_comb begin
    mem_data_out = '0;
    if (final_resp) begin
      if ((mem_op == OP_LDR) || (mem_op == OP_LDI) ||
          (mem_op == OP_TRAP))
        mem_data_out = dmem_rdata;
      else if (mem_op == OP_LDB)
        mem_data_out = addr_in[0] ?
                       {8'h00, dmem_rdata[15:8]} :
                       {8'h00, dmem_rdata[7:0]};
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected
// accesses/results; a negedge monitor checks whatever the DUT presents.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [2:0]  mem_op;
  logic [15:0] addr_in;
  logic [15:0] sr2_in;
  logic [15:0] trapvect8_in;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_en;
  logic [15:0] dmem_wdata;
  logic [15:0] mem_data_out;
  logic        mem_stall;

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .mem_op       (mem_op),
    .addr_in      (addr_in),
    .sr2_in       (sr2_in),
    .trapvect8_in (trapvect8_in),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_byte_en (dmem_byte_en),
    .dmem_wdata   (dmem_wdata),
    .mem_data_out (mem_data_out),
    .mem_stall    (mem_stall)
  );

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          lat;
    logic        fin;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_out[$];
  int          total = 0;
  int          bad   = 0;
  int          run   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push_acc(input logic [15:0] a, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd,
                          input int lat, input logic fin);
    acc_t e;
    e.addr = a; e.wr = wr; e.be = be;
    e.wdata = wd; e.lat = lat; e.fin = fin;
    exp_acc.push_back(e);
  endtask

  // Monitor: compares presented requests and results against queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (dmem_read || dmem_write) begin
        run++;
        if (exp_acc.size() == 0) begin
          check("req_unexpected", 16'(dmem_read || dmem_write), 16'h0);
        end else begin
          check("addr", dmem_address, exp_acc[0].addr);
          check("write", 16'(dmem_write), 16'(exp_acc[0].wr));
          check("read", 16'(dmem_read), 16'(!exp_acc[0].wr));
          check("byte_en", 16'(dmem_byte_en), 16'(exp_acc[0].be));
          check("wdata", dmem_wdata, exp_acc[0].wdata);
          if (dmem_resp) begin
            check("req_cycles", 16'(run), 16'(exp_acc[0].lat));
            check("stall_resp", 16'(mem_stall), 16'(!exp_acc[0].fin));
            void'(exp_acc.pop_front());
            run = 0;
          end else begin
            check("stall_busy", 16'(mem_stall), 16'h1);
          end
        end
      end else begin
        run = 0;
        check("stall_noreq", 16'(mem_stall), 16'(mem_op != 3'd0));
        if (mem_op == 3'd0) check("out_idle", mem_data_out, 16'h0);
      end
      if (!mem_stall && mem_op != 3'd0) begin
        if (exp_out.size() == 0)
          check("out_unexpected", 16'h1, 16'h0);
        else
          check("data_out", mem_data_out, exp_out.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] s, input logic [15:0] tv,
                       input logic [15:0] r1, input int l1,
                       input logic [15:0] r2, input int l2);
    step();
    mem_op = op; addr_in = a; sr2_in = s; trapvect8_in = tv;
    step();
    repeat (l1 - 1) step();
    dmem_resp = 1'b1; dmem_rdata = r1;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'hDEAD;
    if (l2 > 0) begin
      repeat (l2 - 1) step();
      dmem_resp = 1'b1; dmem_rdata = r2;
      step();
      dmem_resp = 1'b0; dmem_rdata = 16'hDEAD;
    end
    mem_op = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_op = 3'd0; addr_in = 16'h0; sr2_in = 16'h0;
    trapvect8_in = 16'h0; dmem_rdata = 16'hDEAD; dmem_resp = 1'b0;
    #12;
    check("rst_read", 16'(dmem_read), 16'h0);
    check("rst_write", 16'(dmem_write), 16'h0);
    check("rst_stall", 16'(mem_stall), 16'h0);
    check("rst_be", 16'(dmem_byte_en), 16'h0);
    step();
    reset = 1'b0;
    repeat (3) step();

    // NONE, LDR (3-cycle latency), NONE
    push_acc(16'h1234, 1'b0, 2'b00, 16'h0, 3, 1'b1);
    exp_out.push_back(16'hBEEF);
    do_op(3'd1, 16'h1235, 16'h0, 16'h0, 16'hBEEF, 3, 16'h0, 0);
    repeat (4) step();

    // LDB odd and even byte
    push_acc(16'h2001, 1'b0, 2'b00, 16'h0, 2, 1'b1);
    exp_out.push_back(16'h00A5);
    do_op(3'd3, 16'h2001, 16'h0, 16'h0, 16'hA55A, 2, 16'h0, 0);
    push_acc(16'h2000, 1'b0, 2'b00, 16'h0, 1, 1'b1);
    exp_out.push_back(16'h005A);
    do_op(3'd3, 16'h2000, 16'h0, 16'h0, 16'hA55A, 1, 16'h0, 0);

    // STB even and odd lane, STR
    push_acc(16'h2000, 1'b1, 2'b01, 16'hCDCD, 2, 1'b1);
    exp_out.push_back(16'h0000);
    do_op(3'd4, 16'h2000, 16'h12CD, 16'h0, 16'hFFFF, 2, 16'h0, 0);
    push_acc(16'h2003, 1'b1, 2'b10, 16'h3434, 1, 1'b1);
    exp_out.push_back(16'h0000);
    do_op(3'd4, 16'h2003, 16'h0034, 16'h0, 16'hFFFF, 1, 16'h0, 0);
    push_acc(16'h0100, 1'b1, 2'b11, 16'hABCD, 2, 1'b1);
    exp_out.push_back(16'h0000);
    do_op(3'd2, 16'h0101, 16'hABCD, 16'h0, 16'hFFFF, 2, 16'h0, 0);

    // LDI through pointer 0x4001
    push_acc(16'h3000, 1'b0, 2'b00, 16'h0, 2, 1'b0);
    push_acc(16'h4000, 1'b0, 2'b00, 16'h0, 2, 1'b1);
    exp_out.push_back(16'h7777);
    do_op(3'd5, 16'h3000, 16'h0, 16'h0, 16'h4001, 2, 16'h7777, 2);

    // STI through pointer 0x5000
    push_acc(16'h3000, 1'b0, 2'b00, 16'h0, 1, 1'b0);
    push_acc(16'h5000, 1'b1, 2'b11, 16'h1111, 3, 1'b1);
    exp_out.push_back(16'h0000);
    do_op(3'd6, 16'h3000, 16'h1111, 16'h0, 16'h5000, 1, 16'hFFFF, 3);

    // TRAP x25 -> vector at 0x004A
    push_acc(16'h004A, 1'b0, 2'b00, 16'h0, 2, 1'b1);
    exp_out.push_back(16'h1234);
    do_op(3'd7, 16'hFFFF, 16'h0, 16'h0025, 16'h1234, 2, 16'h0, 0);

    // Stray response while idle is ignored
    step();
    dmem_resp = 1'b1; dmem_rdata = 16'h5555;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'hDEAD;
    repeat (2) step();

    // Reset in ACC2 of LDI
    push_acc(16'h3000, 1'b0, 2'b00, 16'h0, 1, 1'b0);
    push_acc(16'h6000, 1'b0, 2'b00, 16'h0, 9, 1'b1);
    exp_out.push_back(16'h9999);
    step();
    mem_op = 3'd5; addr_in = 16'h3000;
    step();
    dmem_resp = 1'b1; dmem_rdata = 16'h6000;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'hDEAD;
    step();
    check("acc2_read", 16'(dmem_read), 16'h1);
    reset = 1'b1;
    #1;
    check("rst_async_read", 16'(dmem_read), 16'h0);
    check("rst_stall_op", 16'(mem_stall), 16'h1);
    exp_acc.delete();
    exp_out.delete();
    run = 0;
    mem_op = 3'd0;
    #1;
    check("rst_stall_none", 16'(mem_stall), 16'h0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Normal operation after reset
    push_acc(16'h0042, 1'b0, 2'b00, 16'h0, 1, 1'b1);
    exp_out.push_back(16'hCAFE);
    do_op(3'd1, 16'h0042, 16'h0, 16'h0, 16'hCAFE, 1, 16'h0, 0);
    repeat (3) step();

    check("acc_queue_empty", 16'(exp_acc.size()), 16'h0);
    check("out_queue_empty", 16'(exp_out.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
